// File: rtl/dff_stim_checker_if.sv
// dff_stim_checker_if: bundles the run-control, flop-drive and result
// signals of dff_stim_checker. The master modport is the checker side,
// the slave modport is the environment (controller plus flop under test).
interface dff_stim_checker_if #(
  parameter int IDX_W = 8,
  parameter int ERR_W = 8
);
  logic             start;
  logic [7:0]       seed;
  logic             dut_set;
  logic             dut_clr;
  logic             dut_d;
  logic             dut_q;
  logic             busy;
  logic             done;
  logic             pass;
  logic [ERR_W-1:0] err_count;
  logic [IDX_W-1:0] first_fail_idx;

  modport master (
    input  start, seed, dut_q,
    output dut_set, dut_clr, dut_d, busy, done, pass, err_count, first_fail_idx
  );

  modport slave (
    output start, seed, dut_q,
    input  dut_set, dut_clr, dut_d, busy, done, pass, err_count, first_fail_idx
  );
endinterface

// File: rtl/dff_stim_checker.sv
// dff_stim_checker: pseudo-random stimulus generator and checker for a
// D flop with synchronous set/clr (clr has priority). Each run issues
// NUM_VEC LFSR-derived {set,clr,d} vectors, compares the flop output two
// cycles later against the golden value, and reports pass / error count /
// first failing vector index.
// Optional build macro DFF_STIM_CHECKER_HALT_ON_ERR_EN: the first mismatch
// stops issuing, discards what is still in flight and drains to DONE.
module dff_stim_checker #(
  parameter int NUM_VEC = 64,
  parameter int IDX_W   = 8,
  parameter int ERR_W   = 8
) (
  input  logic               clk,
  input  logic               clr_n,
  dff_stim_checker_if.master bus
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_VEC - 1);
  localparam logic [ERR_W-1:0] ERR_MAX  = '1;

  state_t           r_state;
  state_t           w_state_next;
  logic [7:0]       r_lfsr;
  logic [IDX_W-1:0] r_idx;
  logic             r_drain_cnt;
  logic             r_dut_set;
  logic             r_dut_clr;
  logic             r_dut_d;
  logic             r_pipe_vld [2];
  logic             r_pipe_exp [2];
  logic [IDX_W-1:0] r_pipe_idx [2];
  logic [ERR_W-1:0] r_err_count;
  logic [ERR_W-1:0] w_err_next;
  logic [IDX_W-1:0] r_first_fail_idx;
  logic             r_pass;

  logic w_start_acc;
  logic w_issue;
  logic w_last_vec;
  logic w_mismatch;
  logic w_halt;
  logic w_vec_s;
  logic w_vec_c;
  logic w_vec_d;
  logic w_vec_exp;
  logic w_lfsr_fb;
  logic w_busy;
  logic w_done;

  assign w_start_acc = (r_state == S_IDLE) && bus.start;

  // Vector fields come straight from the current LFSR state; s and c are
  // ANDs of two bits so each is asserted on roughly a quarter of vectors.
  assign w_vec_d   = r_lfsr[0];
  assign w_vec_s   = r_lfsr[1] & r_lfsr[2];
  assign w_vec_c   = r_lfsr[3] & r_lfsr[4];
  assign w_vec_exp = !w_vec_c && (w_vec_s || w_vec_d);

  // Fibonacci feedback for x^8+x^6+x^5+x^4+1.
  assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

  assign w_last_vec = (r_idx == LAST_IDX);
  assign w_mismatch = r_pipe_vld[1] && (bus.dut_q != r_pipe_exp[1]);

`ifdef DFF_STIM_CHECKER_HALT_ON_ERR_EN
  // Any mismatch is necessarily the first one: the pipeline is flushed
  // on it, so nothing else can be checked in this run.
  assign w_halt = w_mismatch;
`else
  assign w_halt = 1'b0;
`endif

  assign w_issue    = (r_state == S_RUN) && !w_halt;
  assign w_err_next = (w_mismatch && (r_err_count != ERR_MAX)) ?
                      r_err_count + 1'b1 : r_err_count;

  // State register.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE:  if (bus.start) w_state_next = S_RUN;
      S_RUN:   if (w_halt || w_last_vec) w_state_next = S_DRAIN;
      S_DRAIN: if (r_drain_cnt) w_state_next = S_DONE;
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
  end

  // State-decoded outputs.
  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      S_RUN, S_DRAIN: w_busy = 1'b1;
      S_DONE:         w_done = 1'b1;
      default:        ;
    endcase
  end

  // Vector generation, flop drive pins and result registers.
  always_ff @(posedge clk) begin
    if (!clr_n) begin
      r_lfsr           <= 8'h01;
      r_idx            <= '0;
      r_drain_cnt      <= 1'b0;
      r_dut_set        <= 1'b0;
      r_dut_clr        <= 1'b1;
      r_dut_d          <= 1'b0;
      r_err_count      <= '0;
      r_first_fail_idx <= '0;
      r_pass           <= 1'b0;
    end else begin
      if (w_start_acc) begin
        r_lfsr <= (bus.seed == 8'h00) ? 8'h01 : bus.seed;
        r_idx  <= '0;
      end else if (w_issue) begin
        r_lfsr <= {r_lfsr[6:0], w_lfsr_fb};
        r_idx  <= r_idx + 1'b1;
      end

      r_drain_cnt <= (r_state == S_DRAIN) ? !r_drain_cnt : 1'b0;

      // Outside of issuing, the flop is parked in clear so q settles at 0.
      if (w_issue) begin
        r_dut_set <= w_vec_s;
        r_dut_clr <= w_vec_c;
        r_dut_d   <= w_vec_d;
      end else begin
        r_dut_set <= 1'b0;
        r_dut_clr <= 1'b1;
        r_dut_d   <= 1'b0;
      end

      if (w_start_acc) begin
        r_err_count      <= '0;
        r_first_fail_idx <= '0;
        r_pass           <= 1'b0;
      end else begin
        r_err_count <= w_err_next;
        if (w_mismatch && (r_err_count == '0)) begin
          r_first_fail_idx <= r_pipe_idx[1];
        end
        // The final comparison lands on the last DRAIN edge, so use the
        // updated count to have pass valid during the done pulse.
        if ((r_state == S_DRAIN) && r_drain_cnt) begin
          r_pass <= (w_err_next == '0);
        end
      end
    end
  end

  // Two-stage expected/index/valid pipeline matching the two cycles from
  // a vector leaving the pins to its effect being visible on dut_q.
  generate
    for (genvar gi = 0; gi < 2; gi++) begin : g_pipe
      if (gi == 0) begin : g_head
        // Stage 0 captures the vector being issued this cycle.
        always_ff @(posedge clk) begin
          if (!clr_n || w_halt) begin
            r_pipe_vld[gi] <= 1'b0;
            r_pipe_exp[gi] <= 1'b0;
            r_pipe_idx[gi] <= '0;
          end else begin
            r_pipe_vld[gi] <= w_issue;
            r_pipe_exp[gi] <= w_vec_exp;
            r_pipe_idx[gi] <= r_idx;
          end
        end
      end else begin : g_tail
        // Later stages shift the previous stage along.
        always_ff @(posedge clk) begin
          if (!clr_n || w_halt) begin
            r_pipe_vld[gi] <= 1'b0;
            r_pipe_exp[gi] <= 1'b0;
            r_pipe_idx[gi] <= '0;
          end else begin
            r_pipe_vld[gi] <= r_pipe_vld[gi-1];
            r_pipe_exp[gi] <= r_pipe_exp[gi-1];
            r_pipe_idx[gi] <= r_pipe_idx[gi-1];
          end
        end
      end
    end
  endgenerate

  assign bus.dut_set        = r_dut_set;
  assign bus.dut_clr        = r_dut_clr;
  assign bus.dut_d          = r_dut_d;
  assign bus.busy           = w_busy;
  assign bus.done           = w_done;
  assign bus.pass           = r_pass;
  assign bus.err_count      = r_err_count;
  assign bus.first_fail_idx = r_first_fail_idx;

endmodule

// File: tb/tb_dff_stim_checker.sv
// tb_dff_stim_checker: drives dff_stim_checker against a behavioural flop
// (ideal, stuck-at-0, or set-over-clr) and checks every output each cycle
// against a run-level model built from the LFSR and golden-flop rules.
module tb_dff_stim_checker;
  localparam int N     = 64;
  localparam int IDX_W = 8;
  localparam int ERR_W = 8;

  logic clk = 1'b0;
  logic clr_n;
  always #5 clk = ~clk;

  dff_stim_checker_if #(.IDX_W(IDX_W), .ERR_W(ERR_W)) bus_if ();

  dff_stim_checker #(.NUM_VEC(N), .IDX_W(IDX_W), .ERR_W(ERR_W)) dut (
    .clk   (clk),
    .clr_n (clr_n),
    .bus   (bus_if)
  );

  int checks = 0;
  int errors = 0;
  int fault_mode = 0;   // 0 ideal, 1 stuck-at-0, 2 set has priority

  // Flop under test, in its good and set-priority flavours.
  logic q_good, q_setpri;
  always_ff @(posedge clk) begin
    q_good   <= bus_if.dut_clr ? 1'b0 : (bus_if.dut_set ? 1'b1 : bus_if.dut_d);
    q_setpri <= bus_if.dut_set ? 1'b1 : (bus_if.dut_clr ? 1'b0 : bus_if.dut_d);
  end
  assign bus_if.dut_q = (fault_mode == 1) ? 1'b0 :
                        (fault_mode == 2) ? q_setpri : q_good;

  // ---------------- run-level model ----------------
  int   m_t = -1;        // cycle number inside the current run (1 = first RUN cycle)
  int   m_tdone = 0;     // cycle of the done pulse
  int   m_lastpin = 0;   // last cycle whose pins carry a vector
  int   m_first = -1;    // first mismatching vector index
  logic m_vs [N];
  logic m_vc [N];
  logic m_vd [N];
  logic m_mis [N];
  bit   check_en = 0;

  function automatic logic [7:0] lfsr_next(input logic [7:0] v);
    logic fb;
    fb = ^(v & 8'hB8);   // tap polynomial x^8+x^6+x^5+x^4+1
    return {v[6:0], fb};
  endfunction

  function automatic logic golden(input logic s, input logic c, input logic d);
    if (c) return 1'b0;
    if (s) return 1'b1;
    return d;
  endfunction

  function automatic logic faulty(input int mode, input logic s, input logic c, input logic d);
    if (mode == 1) return 1'b0;
    if (mode == 2) return s ? 1'b1 : (c ? 1'b0 : d);
    return golden(s, c, d);
  endfunction

  task automatic model_start(input logic [7:0] sd);
    logic [7:0] l;
    l = (sd == 8'h00) ? 8'h01 : sd;
    m_first = -1;
    for (int i = 0; i < N; i++) begin
      m_vd[i]  = l[0];
      m_vs[i]  = l[1] & l[2];
      m_vc[i]  = l[3] & l[4];
      m_mis[i] = faulty(fault_mode, m_vs[i], m_vc[i], m_vd[i]) != golden(m_vs[i], m_vc[i], m_vd[i]);
      if (m_mis[i] && m_first < 0) m_first = i;
      l = lfsr_next(l);
    end
    m_tdone   = N + 3;
    m_lastpin = N + 1;
`ifdef DFF_STIM_CHECKER_HALT_ON_ERR_EN
    if (m_first >= 0 && m_first + 3 <= N) begin
      m_tdone   = m_first + 6;
      m_lastpin = m_first + 3;
    end
`endif
    m_t = 1;
  endtask

  // Errors visible in cycle t: vector i is compared at the end of cycle i+3.
  function automatic int model_err(input int t);
    int cnt = 0;
    for (int i = 0; i < N; i++) begin
      if (i <= t - 4) begin
`ifdef DFF_STIM_CHECKER_HALT_ON_ERR_EN
        if (i == m_first) cnt++;
`else
        if (m_mis[i]) cnt++;
`endif
      end
    end
    if (cnt > (1 << ERR_W) - 1) cnt = (1 << ERR_W) - 1;
    return cnt;
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s t=%0d actual=%0d required=%0d", name, m_t, act, exp);
    end
  endtask

  // Per-cycle compare, then advance the model using the inputs that the
  // coming clock edge will sample.
  int e_busy, e_done, e_set, e_clr, e_d, e_err, e_ffi, e_pass;
  initial begin
    forever begin
      @(negedge clk);
      if (check_en) begin
        e_busy = 0; e_done = 0; e_set = 0; e_clr = 1; e_d = 0;
        e_err = 0; e_ffi = 0; e_pass = 0;
        if (m_t >= 1) begin
          e_busy = (m_t <= m_tdone - 1) ? 1 : 0;
          e_done = (m_t == m_tdone) ? 1 : 0;
          if (m_t >= 2 && m_t <= m_lastpin) begin
            e_set = int'(m_vs[m_t-2]);
            e_clr = int'(m_vc[m_t-2]);
            e_d   = int'(m_vd[m_t-2]);
          end
          e_err  = model_err(m_t);
          e_ffi  = (m_first >= 0 && m_first <= m_t - 4) ? m_first : 0;
          e_pass = (m_t >= m_tdone && model_err(N + 4) == 0) ? 1 : 0;
        end
        chk("busy", int'(bus_if.busy), e_busy);
        chk("done", int'(bus_if.done), e_done);
        chk("dut_set", int'(bus_if.dut_set), e_set);
        chk("dut_clr", int'(bus_if.dut_clr), e_clr);
        chk("dut_d", int'(bus_if.dut_d), e_d);
        chk("err_count", int'(bus_if.err_count), e_err);
        chk("first_fail_idx", int'(bus_if.first_fail_idx), e_ffi);
        chk("pass", int'(bus_if.pass), e_pass);
      end
      if (!clr_n) begin
        m_t = -1;
        m_first = -1;
        check_en = 1;
      end else if (bus_if.start && (m_t < 1 || m_t > m_tdone)) begin
        model_start(bus_if.seed);
      end else if (m_t >= 1) begin
        m_t++;
      end
    end
  end

  // ---------------- driver ----------------
  int r_busy, r_done_at, r_dones, r_err, r_ffi, r_pass, r_v0;

  // One run: start in cycle 0, optional extra start pulse at cycle glitch_at,
  // optional reset at cycle abort_at. Cycle budget bounds the wait.
  task automatic run(input logic [7:0] sd, input int mode, input int glitch_at, input int abort_at);
    int k;
    int budget;
    budget = (abort_at > 0) ? 100 : 200;
    fault_mode = mode;
    r_busy = 0; r_done_at = -1; r_dones = 0; r_v0 = -1;
    r_err = 0; r_ffi = 0; r_pass = 0;
    @(posedge clk); #1;
    bus_if.seed  = sd;
    bus_if.start = 1'b1;
    k = 0;
    while (k < budget && (abort_at > 0 || r_done_at < 0)) begin
      @(posedge clk); #1;
      k++;
      bus_if.start = (k == glitch_at);
      clr_n = (k == abort_at) ? 1'b0 : 1'b1;
      @(negedge clk);
      if (k == 2) r_v0 = {bus_if.dut_set, bus_if.dut_clr, bus_if.dut_d};
      if (bus_if.busy) r_busy++;
      if (bus_if.done) begin
        r_dones++;
        if (r_done_at < 0) begin
          r_done_at = k;
          r_err  = int'(bus_if.err_count);
          r_ffi  = int'(bus_if.first_fail_idx);
          r_pass = int'(bus_if.pass);
        end
      end
      if (abort_at > 0 && k == abort_at + 1) begin
        chk("abort_busy", int'(bus_if.busy), 0);
        chk("abort_err", int'(bus_if.err_count), 0);
        chk("abort_clr", int'(bus_if.dut_clr), 1);
      end
    end
    bus_if.start = 1'b0;
    clr_n = 1'b1;
    if (abort_at > 0) begin
      chk("abort_no_done", r_dones, 0);
    end else if (r_done_at < 0) begin
      checks++;
      errors++;
      $display("FAIL run_timeout seed=%02h actual=no_done required=done_within_%0d", sd, budget);
    end else begin
      chk("end_err", r_err, model_err(N + 4));
    end
    $display("run seed=%02h mode=%0d glitch=%0d abort=%0d done_at=%0d busy=%0d err=%0d ffi=%0d pass=%0d",
             sd, mode, glitch_at, abort_at, r_done_at, r_busy, r_err, r_ffi, r_pass);
  endtask

  initial begin
    int first_sc;
    bus_if.start = 1'b0;
    bus_if.seed  = 8'h00;
    clr_n = 1'b0;

    // Pin the model helpers with hand-computed values.
    chk("lfsr_01", int'(lfsr_next(8'h01)), 8'h02);
    chk("lfsr_80", int'(lfsr_next(8'h80)), 8'h01);
    chk("lfsr_A5", int'(lfsr_next(8'hA5)), 8'h4A);
    chk("golden_clr_pri", int'(golden(1'b1, 1'b1, 1'b1)), 0);
    chk("golden_set", int'(golden(1'b1, 1'b0, 1'b0)), 1);

    // Reset two cycles, then idle five.
    repeat (2) @(posedge clk);
    #1 clr_n = 1'b1;
    repeat (5) @(negedge clk);
    chk("rst_busy", int'(bus_if.busy), 0);
    chk("rst_done", int'(bus_if.done), 0);
    chk("rst_dut_clr", int'(bus_if.dut_clr), 1);
    chk("rst_dut_set", int'(bus_if.dut_set), 0);
    chk("rst_dut_d", int'(bus_if.dut_d), 0);
    chk("rst_pass", int'(bus_if.pass), 0);
    chk("rst_err", int'(bus_if.err_count), 0);

    // Ideal flop, seed A5.
    run(8'hA5, 0, 0, 0);
    chk("ideal_busy_cycles", r_busy, 66);
    chk("ideal_done_at", r_done_at, 67);
    chk("ideal_pass", r_pass, 1);
    chk("ideal_err", r_err, 0);
    chk("ideal_ffi", r_ffi, 0);

    // Stuck-at-0 flop, seed 01: vector 0 is d=1 only, so index 0 fails.
    run(8'h01, 1, 0, 0);
    chk("stuck_v0", r_v0, 3'b001);
    chk("stuck_pass", r_pass, 0);
    chk("stuck_ffi", r_ffi, 0);
`ifdef DFF_STIM_CHECKER_HALT_ON_ERR_EN
    chk("halt_err", r_err, 1);
    chk("halt_done_at", r_done_at, 6);
`else
    chk("stuck_done_at", r_done_at, 67);
`endif

    // Set-over-clr flop, seed FF: vector 0 has s=c=1, so index 0 fails.
    run(8'hFF, 2, 0, 0);
    chk("setpri_v0", r_v0, 3'b111);
    chk("setpri_ffi", r_ffi, 0);
    first_sc = -1;
    for (int i = N - 1; i >= 0; i--) if (m_vs[i] && m_vc[i]) first_sc = i;
    chk("setpri_first_sc", r_ffi, first_sc);

    // Abort at cycle 20 with an ignored start at cycle 10.
    run(8'h3C, 0, 10, 20);

    // Ignored mid-run start leaves the run length unchanged.
    run(8'h01, 0, 10, 0);
    chk("glitch_done_at", r_done_at, 67);

    // Seed 0 behaves as seed 01.
    run(8'h00, 0, 0, 0);
    chk("seed0_v0", r_v0, 3'b001);
    chk("seed0_done_at", r_done_at, 67);

    // Randomised runs.
    for (int n = 0; n < 10; n++) begin
      run(8'($urandom), int'($urandom_range(0, 2)), int'($urandom_range(1, 67)),
          (n == 7) ? int'($urandom_range(3, 60)) : 0);
    end

    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
